// File: rtl/wb_stage_if.sv
// MEM->WB bus: MEM-stage result, data-memory read word and the
// register-file write port driven back out of writeback.
interface wb_stage_if #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
);
  logic                   valid_m;
  logic [XLEN-1:0]        pc_m;
  logic [RFIDX_WIDTH-1:0] rd_m;
  logic                   regwrite_m;
  logic [1:0]             wbsel_m;
  logic [2:0]             funct3_m;
  logic [XLEN-1:0]        aluout_m;
  logic [XLEN-1:0]        dmem_rdata;
  logic                   we_w;
  logic [RFIDX_WIDTH-1:0] wa_w;
  logic [XLEN-1:0]        wd_w;
  logic [XLEN-1:0]        pc_w;
  logic                   ldmis_w;

  modport master (
    output valid_m, pc_m, rd_m, regwrite_m,
    output wbsel_m, funct3_m, aluout_m, dmem_rdata,
    input  we_w, wa_w, wd_w, pc_w, ldmis_w
  );

  modport slave (
    input  valid_m, pc_m, rd_m, regwrite_m,
    input  wbsel_m, funct3_m, aluout_m, dmem_rdata,
    output we_w, wa_w, wd_w, pc_w, ldmis_w
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, load alignment and register-file writeback.
// Also keeps the retired-instruction counter.
module wb_stage #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall,
  input  logic                 flush,
  wb_stage_if.slave            bus,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef struct packed {
    logic                   valid;
    logic [XLEN-1:0]        pc;
    logic [RFIDX_WIDTH-1:0] rd;
    logic                   regwrite;
    logic [1:0]             wbsel;
    logic [2:0]             funct3;
    logic [XLEN-1:0]        alu;
  } mem_wb_t;

  mem_wb_t mw_d;
  mem_wb_t mw_q;

  assign mw_d = '{
    valid:    bus.valid_m,
    pc:       bus.pc_m,
    rd:       bus.rd_m,
    regwrite: bus.regwrite_m,
    wbsel:    bus.wbsel_m,
    funct3:   bus.funct3_m,
    alu:      bus.aluout_m
  };

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mw_q <= '0;
    end else if (flush) begin
      mw_q.valid <= 1'b0;
    end else if (!stall) begin
      mw_q <= mw_d;
    end
  end

  // A stalled instruction is counted on the edge it finally leaves WB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instret <= '0;
    end else if (mw_q.valid && !stall) begin
      instret <= instret + CNT_WIDTH'(1);
    end
  end

  logic [1:0]      a;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic            is_b;
  logic            is_bu;
  logic            is_h;
  logic            is_hu;
  logic            is_w;
  logic            ld_bad;
  logic            ld_misal;
  logic [XLEN-1:0] ld_data;

  assign a     = mw_q.alu[1:0];
  assign ld_b  = bus.dmem_rdata[{a, 3'b000} +: 8];
  assign ld_h  = a[1] ? bus.dmem_rdata[31:16]
                      : bus.dmem_rdata[15:0];
  assign is_b  = mw_q.funct3 == 3'b000;
  assign is_h  = mw_q.funct3 == 3'b001;
  assign is_w  = mw_q.funct3 == 3'b010;
  assign is_bu = mw_q.funct3 == 3'b100;
  assign is_hu = mw_q.funct3 == 3'b101;

  always_comb begin
    ld_data = '0;
    ld_bad  = 1'b0;
    unique case (1'b1)
      is_b:    ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
      is_bu:   ld_data = {{(XLEN-8){1'b0}}, ld_b};
      is_h:    ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
      is_hu:   ld_data = {{(XLEN-16){1'b0}}, ld_h};
      is_w:    ld_data = bus.dmem_rdata;
      default: ld_bad  = 1'b1;
    endcase
  end

  assign ld_misal = ((is_h | is_hu) & a[0])
                  | (is_w & (a != 2'b00));

  always_comb begin
    bus.wd_w = '0;
    unique case (mw_q.wbsel)
      2'b00:   bus.wd_w = mw_q.alu;
      2'b01:   bus.wd_w = ld_data;
      2'b10:   bus.wd_w = mw_q.pc + XLEN'(4);
      default: bus.wd_w = '0;
    endcase
  end

  assign bus.we_w    = mw_q.valid & mw_q.regwrite
                     & (mw_q.rd != '0);
  assign bus.wa_w    = mw_q.rd;
  assign bus.pc_w    = mw_q.pc;
  assign bus.ldmis_w = mw_q.valid & (mw_q.wbsel == 2'b01)
                     & (ld_misal | ld_bad);

endmodule
